// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes one operand bit per clock, LSB first,
// and presents a registered sum/carry/overflow with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic sum_bit;
    logic carry_next;
    logic last_bit;

    assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry;
    assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    assign last_bit   = (cnt == CW'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted on capture and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b ^ {WIDTH{sub}};
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    carry   <= carry_next;
                    res_reg <= {sum_bit, res_reg[WIDTH-1:1]};
                    cnt     <= cnt + CW'(1);
                    // On the MSB cycle, carry is the carry into the MSB.
                    if (last_bit) begin
                        sum  <= {sum_bit, res_reg[WIDTH-1:1]};
                        cout <= carry_next;
                        ovf  <= carry ^ carry_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed vectors, mid-run reset,
// and a back-to-back random run against a behavioural reference.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_cyc = 0;
    bit b2b_mode = 1'b0;
    bit have_prev = 1'b0;
    logic [9:0] exp_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain wide addition, overflow from operand/result sign bits.
    function automatic logic [9:0] model(input logic [7:0] a_v, input logic [7:0] b_v,
                                         input logic cin_v, input logic sub_v);
        logic [7:0] bb;
        logic [8:0] full;
        logic [7:0] s;
        logic       o;
        bb   = sub_v ? ~b_v : b_v;
        full = {1'b0, a_v} + {1'b0, bb} + (sub_v ? 9'd1 : {8'd0, cin_v});
        s    = full[7:0];
        o    = (a_v[7] == bb[7]) && (s[7] != a_v[7]);
        return {s, full[8], o};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Issue one operation from IDLE, scramble inputs during RUN, and check the handshake timing.
    task automatic applyStimulus(input logic [7:0] a_v, input logic [7:0] b_v,
                                 input logic cin_v, input logic sub_v, input logic [9:0] exp_v);
        int busy_cycles;
        int done_at;
        @(negedge clk);
        a = a_v; b = b_v; cin = cin_v; sub = sub_v; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("accept_busy", 64'(busy), 64'd1);
        exp_q.push_back(exp_v);
        a = ~a_v; b = b_v + 8'd1; cin = ~cin_v; sub = ~sub_v;
        busy_cycles = 0;
        done_at = -1;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) done_at = i;
        end
        checkOutput("busy_cycles", 64'(busy_cycles), 64'd8);
        checkOutput("done_offset", 64'(done_at), 64'd8);
        @(negedge clk);
        checkOutput("done_single_pulse", 64'({busy, done}), 64'd0);
    endtask

    // Monitor: every done pulse pops one expected result.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 with sum=0x%0h, expected no done (t=%0t)", sum, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result", 64'({sum, cout, ovf}), 64'(e));
                end
                if (b2b_mode) begin
                    if (have_prev) checkOutput("done_period", 64'(cyc - prev_cyc), 64'd10);
                    prev_cyc  = cyc;
                    have_prev = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        integer seed;
        logic [7:0] ra, rb;
        logic       rc, rs;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        checkOutput("reset_outputs", 64'({busy, done, sum, cout, ovf}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors: {sum, cout, ovf} hand-computed.
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, {8'h10, 1'b0, 1'b0});
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, {8'h01, 1'b1, 1'b0});
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1});
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, {8'h00, 1'b0, 1'b0});
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, {8'hFF, 1'b1, 1'b0});
        applyStimulus(8'h05, 8'h07, 1'b1, 1'b1, {8'hFE, 1'b0, 1'b0});
        applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0});
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1});

        // Abort during the 4th RUN cycle; nothing is queued, so any done is flagged.
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("rst_test_accept", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_midrun_outputs", 64'({busy, done, sum, cout, ovf}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h03, 8'h04, 1'b0, 1'b0, {8'h07, 1'b0, 1'b0});

        // Back-to-back with start held high; inputs are junk outside the IDLE cycle.
        seed = 32'd20240611;
        b2b_mode  = 1'b1;
        have_prev = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            ra = 8'($random(seed));
            rb = 8'($random(seed));
            rc = 1'($random(seed));
            rs = 1'($random(seed));
            a = ra; b = rb; cin = rc; sub = rs; start = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("b2b_accept", 64'(busy), 64'd1);
            exp_q.push_back(model(ra, rb, rc, rs));
            for (int j = 0; j < 9; j++) begin
                @(negedge clk);
                a   = 8'($random(seed));
                b   = 8'($random(seed));
                cin = 1'($random(seed));
                sub = 1'($random(seed));
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        b2b_mode = 1'b0;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
